wave_meter: RTL
===============

Name: wave_meter

Overview:
Measurement receiver for the NCO's 8-bit wave output. It sits at the far end of the nco wave_out bus and detects rising midscale crossings with hysteresis. Over N_PERIODS consecutive periods it measures the total period length in samples, plus the minimum and maximum sample values. Results feed the loopback self-test and the frequency-calibration logic.

Parameters:
MID, 128, midscale threshold (unsigned 8-bit).
HYST, 8, hysteresis half-width; low arm level = MID-HYST, high trigger level = MID+HYST.
N_PERIODS, 4, number of periods per measurement; range 1..255.
CNT_W, 24, width of the period accumulator.

Ports:
clk_50MHz  input  1  system clock.
reset  input  1  synchronous, active-high reset.
enable  input  1  measurement enable; low forces IDLE.
sample_in  input  8  unsigned waveform sample.
sample_valid  input  1  sample_in is valid this cycle.
period_sum  output CNT_W  valid samples spanning N_PERIODS periods.
amp_min  output  8  minimum sample over the measurement.
amp_max  output  8  maximum sample over the measurement.
result_valid  output  1  one-cycle pulse when the result registers update.
timeout  output  1  last result ended by accumulator saturation.
busy  output  1  high in ARM or MEASURE.

Behaviour:
- Interface: one clock, clk_50MHz. reset is synchronous, active-high, and overrides everything.
- Reset values:
  - Outputs: period_sum=0, amp_min=0, amp_max=0, result_valid=0, timeout=0, busy=0.
  - Internal: state=IDLE, low_armed=0.
- Crossing detector, evaluated only when sample_valid=1:
  - sample_in < MID-HYST sets low_armed.
  - A crossing occurs when low_armed=1 and sample_in >= MID+HYST. The crossing clears low_armed.
  - Samples inside the band leave low_armed unchanged.
  - low_armed is cleared in IDLE.
- State machine:
  - IDLE: go to ARM when enable=1.
  - ARM: wait for a crossing. On the crossing sample:
    - cnt=0, crossings=0.
    - min/max are loaded with that sample.
    - Go to MEASURE.
  - MEASURE, on each valid sample:
    - cnt+=1.
    - min/max are updated including that sample.
    - On a crossing, crossings+=1.
    - When crossings reaches N_PERIODS, go to DONE.
  - DONE, for one cycle:
    - Register cnt into period_sum and min/max into amp_min/amp_max.
    - Pulse result_valid=1 and set timeout accordingly.
    - Go to ARM, or to IDLE if enable=0. The next measurement needs a fresh crossing in ARM.
- Latency: result_valid is asserted on the clock edge after the cycle carrying the Nth crossing sample.
- Outputs hold their values between DONE pulses.
- Saturation: if cnt equals 2^CNT_W-1 when a valid sample arrives in MEASURE, cnt holds and the FSM goes to DONE with timeout=1. period_sum then reads all ones, and amp_min/amp_max reflect the samples seen.
- A normal completion sets timeout=0.
- enable low in ARM or MEASURE: go to IDLE next cycle and abort the measurement with no result_valid. Outputs keep their last values.
- sample_valid=0: no counter, min/max or crossing change; the FSM waits.
- Simultaneous saturation and Nth crossing on the same sample: treated as a normal completion, timeout=0.
- A DC or in-band input never produces a result; busy stays high.
- busy=1 in ARM and MEASURE, 0 in IDLE and DONE.

Optional Feature:
WAVE_METER_AVG_EN:
- Defined: adds output port period_avg (CNT_W bits), registered in DONE alongside period_sum, equal to period_sum / N_PERIODS. The division is an integer divide, floor, combinational from cnt. When N_PERIODS is a power of two it must synthesise to a shift. period_avg resets to 0 and reads all ones on timeout.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Square wave 0/255, period 16, sample_valid=1, N_PERIODS=4 -> first result_valid with period_sum=64, amp_min=0, amp_max=255, timeout=0; with WAVE_METER_AVG_EN, period_avg=16.
- Period-32 sawtooth 0..248 step 8, sample_valid toggling every cycle -> period_sum=128; the result is unaffected by the gaps.
- Noise injection: sample alternating 125/131 for 10 samples inside a period-16 square wave -> no extra crossings; period_sum stays 64.
- Constant 200 input, CNT_W=8 -> after ARM needs a crossing, busy stays 1 and result_valid is never asserted. Then square period 100, N_PERIODS=4 -> saturation; result_valid with period_sum=255, timeout=1.
- enable dropped mid-MEASURE -> IDLE the next cycle, no result_valid, previous outputs retained. Re-enable -> a new result after a full N_PERIODS.
- reset asserted mid-MEASURE, coincident with a crossing -> on the next cycle all outputs are 0 and state is IDLE; no result_valid pulse.

Source files
------------

// File: rtl/wave_meter.sv
// Measures N_PERIODS periods of a sampled waveform: total length in samples plus min/max.
// Optional average output enabled by defining WAVE_METER_AVG_EN.
`timescale 1ns/1ps
module wave_meter #(
   parameter logic [7:0] MID       = 8'd128,
   parameter logic [7:0] HYST      = 8'd8,
   parameter int         N_PERIODS = 4,
   parameter int         CNT_W     = 24
) (
   input  logic             clk_50MHz,
   input  logic             reset,
   input  logic             enable,
   input  logic [7:0]       sample_in,
   input  logic             sample_valid,
   output logic [CNT_W-1:0] period_sum,
   output logic [7:0]       amp_min,
   output logic [7:0]       amp_max,
   output logic             result_valid,
   output logic             timeout,
   output logic             busy,
`ifdef WAVE_METER_AVG_EN
   output logic [CNT_W-1:0] period_avg,
`endif
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_MEASURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [7:0]       LO_LVL  = MID - HYST;
   localparam logic [7:0]       HI_LVL  = MID + HYST;
   localparam logic [7:0]       N_LAST  = 8'(N_PERIODS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state;
   logic             r_low_armed;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_cross;
   logic [7:0]       r_min;
   logic [7:0]       r_max;

   logic             w_low;
   logic             w_cross;
   logic             w_sat;
   logic             w_last;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [7:0]       w_min_nxt;
   logic [7:0]       w_max_nxt;

   // Hysteresis: a crossing needs a sample below the low level first, then one at/above the high level.
   assign w_low     = sample_valid && (sample_in < LO_LVL);
   assign w_cross   = sample_valid && r_low_armed && (sample_in >= HI_LVL);
   assign w_sat     = (r_cnt == CNT_MAX);
   assign w_last    = w_cross && (r_cross == N_LAST);
   assign w_cnt_nxt = w_sat ? r_cnt : (r_cnt + CNT_ONE);
   assign w_min_nxt = (sample_in < r_min) ? sample_in : r_min;
   assign w_max_nxt = (sample_in > r_max) ? sample_in : r_max;
   assign dbg_state = r_state;

`ifdef WAVE_METER_AVG_EN
   localparam logic [CNT_W-1:0] N_DIV = CNT_W'(N_PERIODS);
   logic [CNT_W-1:0] w_avg;
   assign w_avg = w_cnt_nxt / N_DIV;
`endif

   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_low_armed  <= 1'b0;
         r_cnt        <= '0;
         r_cross      <= '0;
         r_min        <= '0;
         r_max        <= '0;
         period_sum   <= '0;
         amp_min      <= '0;
         amp_max      <= '0;
         result_valid <= 1'b0;
         timeout      <= 1'b0;
         busy         <= 1'b0;
`ifdef WAVE_METER_AVG_EN
         period_avg   <= '0;
`endif
      end else begin
         result_valid <= 1'b0;

         if (r_state == S_IDLE)
            r_low_armed <= 1'b0;
         else if (w_low)
            r_low_armed <= 1'b1;
         else if (w_cross)
            r_low_armed <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_state <= S_ARM;
                  busy    <= 1'b1;
               end
            end
            S_ARM: begin
               if (!enable) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end else if (w_cross) begin
                  r_cnt   <= '0;
                  r_cross <= '0;
                  r_min   <= sample_in;
                  r_max   <= sample_in;
                  r_state <= S_MEASURE;
               end
            end
            S_MEASURE: begin
               if (!enable) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end else if (sample_valid) begin
                  r_cnt <= w_cnt_nxt;
                  r_min <= w_min_nxt;
                  r_max <= w_max_nxt;
                  if (w_cross)
                     r_cross <= r_cross + 8'd1;
                  // The Nth crossing wins over saturation on the same sample.
                  if (w_last || w_sat) begin
                     r_state      <= S_DONE;
                     busy         <= 1'b0;
                     result_valid <= 1'b1;
                     period_sum   <= w_cnt_nxt;
                     amp_min      <= w_min_nxt;
                     amp_max      <= w_max_nxt;
                     timeout      <= !w_last;
`ifdef WAVE_METER_AVG_EN
                     period_avg   <= w_last ? w_avg : '1;
`endif
                  end
               end
            end
            S_DONE: begin
               if (enable) begin
                  r_state <= S_ARM;
                  busy    <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
